// File: rtl/md_hilo_unit.sv
// md_hilo_unit: HI/LO register file with a single-cycle 32x32 multiplier
// and a 32-cycle radix-2 restoring divider. Divides stall the pipeline
// for the issue cycle plus 32 iteration cycles, then retire in DONE.
module md_hilo_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  choice_md,    // {div, divu, mul, multu}
  input  logic [4:0]  choice_hilo,  // {mfhi, mflo, mthi, mtlo, md_wr}
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] mul_out,
  output logic        div_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [4:0]  cnt_q, cnt_d;
  // Divider datapath: partial remainder, dividend/quotient shift register,
  // divisor magnitude, and the result sign flags latched at issue.
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;

  // Opcode decode
  logic op_div, op_divu, op_multu;
  logic op_mfhi, op_mflo, op_mthi, op_mtlo;

  assign op_div   = choice_md[3];
  assign op_divu  = choice_md[2];
  assign op_multu = choice_md[0];
  assign op_mfhi  = choice_hilo[4];
  assign op_mflo  = choice_hilo[3];
  assign op_mthi  = choice_hilo[2];
  assign op_mtlo  = choice_hilo[1];

  // mul needs no state of its own and md_wr is only meaningful to the
  // control unit; both are intentionally not consumed here.
  logic unused_ctrl;
  assign unused_ctrl = choice_md[1] ^ choice_hilo[0];

  // Operand magnitudes for signed divide; divu uses raw values.
  // div has priority over divu when both are asserted.
  logic [31:0] rs_abs, rt_abs;
  logic        rt_zero;

  assign rs_abs  = (op_div && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign rt_abs  = (op_div && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
  assign rt_zero = (rt_data == 32'd0);

  // Low 32 bits of a product are identical for signed and unsigned
  // operands, so the signed mul result needs no sign handling.
  assign mul_out = rs_data * rt_data;

  logic [63:0] umul;
  assign umul = {32'd0, rs_data} * {32'd0, rt_data};

  // One restoring step: shift in the next dividend bit, trial-subtract
  // the divisor, keep the difference when it does not go negative.
  logic [32:0] rem_sh, diff;
  logic        take;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] q_fix, r_fix;

  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign take   = ~diff[32];
  assign rem_nx = take ? diff[31:0] : rem_sh[31:0];
  assign quo_nx = {quo_q[30:0], take};
  // Quotient truncates toward zero; remainder follows the dividend sign.
  assign q_fix  = negq_q ? (32'd0 - quo_nx) : quo_nx;
  assign r_fix  = negr_q ? (32'd0 - rem_nx) : rem_nx;

  // Next-state, stall and completion decode
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    stall    = 1'b0;
    div_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_div || op_divu) begin
          stall = 1'b1;
          if (rt_zero) begin
            // Divide by zero resolves immediately, no iterations.
            hi_d    = rs_data;
            lo_d    = 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else begin
            quo_d   = rs_abs;
            dvs_d   = rt_abs;
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            negq_d  = op_div & (rs_data[31] ^ rt_data[31]);
            negr_d  = op_div & rs_data[31];
            state_d = S_BUSY;
          end
        end else if (op_multu) begin
          hi_d = umul[63:32];
          lo_d = umul[31:0];
        end else begin
          if (op_mthi) hi_d = rs_data;
          if (op_mtlo) lo_d = rs_data;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = r_fix;
          lo_d    = q_fix;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The retiring divide is still on choice_md; do not reissue.
        div_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // While reset is held, the unit presents an idle, non-stalling face.
    if (!rst_n) begin
      stall    = 1'b0;
      div_done = 1'b0;
    end
  end

  // State and register update; reset discards any partial divide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  // Register read port: no bypass of a same-cycle mthi/mtlo.
  assign hilo_rdata = op_mfhi ? hi_q : (op_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_md_hilo_unit.sv
// Scoreboard bench for md_hilo_unit: stimulus queues expectations, a
// negedge monitor compares them when the DUT presents a result.
module tb_md_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  choice_md;
  logic [4:0]  choice_hilo;
  logic [31:0] rs_data, rt_data;
  logic        stall, div_done;
  logic [31:0] hilo_rdata, mul_out, hi, lo;

  md_hilo_unit dut (
    .clk(clk), .rst_n(rst_n), .choice_md(choice_md), .choice_hilo(choice_hilo),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .hilo_rdata(hilo_rdata),
    .mul_out(mul_out), .div_done(div_done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } div_exp_t;

  typedef struct {
    string       name;
    int          sel;   // 0 hi,1 lo,2 stall,3 mul_out,4 hilo_rdata,5 div_done,6 pending divs
    logic [31:0] exp;
  } chk_t;

  div_exp_t div_q[$];
  chk_t     chk_q[$];
  int       checks = 0;
  int       errors = 0;
  int       scnt   = 0;

  function automatic logic [31:0] pick(int sel);
    case (sel)
      0: return hi;
      1: return lo;
      2: return {31'd0, stall};
      3: return mul_out;
      4: return hilo_rdata;
      5: return {31'd0, div_done};
      default: return div_q.size();
    endcase
  endfunction

  // Monitor: divide results pop on div_done, point checks drain each cycle.
  always @(negedge clk) begin
    div_exp_t e;
    chk_t     c;
    logic [31:0] act;
    if (!rst_n) begin
      scnt = 0;
    end else begin
      if (div_done) begin
        if (div_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_div_done got=1 want=0");
        end else begin
          e = div_q.pop_front();
          checks += 3;
          if (hi !== e.hi) begin errors++; $display("FAIL %s_hi got=%h want=%h", e.name, hi, e.hi); end
          if (lo !== e.lo) begin errors++; $display("FAIL %s_lo got=%h want=%h", e.name, lo, e.lo); end
          if (scnt != e.stalls) begin errors++; $display("FAIL %s_stalls got=%0d want=%0d", e.name, scnt, e.stalls); end
        end
        scnt = 0;
      end
      if (stall) scnt++;
    end
    while (chk_q.size() > 0) begin
      c   = chk_q.pop_front();
      act = pick(c.sel);
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s got=%h want=%h", c.name, act, c.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set(input logic [3:0] md, input logic [4:0] hl,
                     input logic [31:0] a, input logic [31:0] b);
    choice_md = md; choice_hilo = hl; rs_data = a; rt_data = b;
  endtask

  task automatic chk(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.sel = sel; c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic do_div(input string name, input logic [3:0] md,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input int stalls);
    div_exp_t e;
    e.name = name; e.hi = ehi; e.lo = elo; e.stalls = stalls;
    div_q.push_back(e);
    set(md, 5'd0, a, b);
    repeat (stalls + 1) step();
    set(4'd0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    div_exp_t e;
    rst_n = 1'b0;
    set(4'd0, 5'd0, 32'd0, 32'd0);
    step(); step();
    chk("rst_hi", 0, 32'd0);
    chk("rst_lo", 1, 32'd0);
    chk("rst_stall", 2, 32'd0);
    chk("rst_done", 5, 32'd0);
    step();

    // First issue right as reset releases
    rst_n = 1'b1;
    chk("divu_issue_stall", 2, 32'd1);
    do_div("divu_100_7", 4'b0100, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    chk("divu_hold_lo", 1, 32'd14);
    step();

    do_div("div_m7_2", 4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_div("div_7_m2", 4'b1000, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
    do_div("div_ovf", 4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
    step();

    // multu, single cycle, no stall
    set(4'b0001, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_stall", 2, 32'd0);
    step();
    set(4'd0, 5'd0, 32'd0, 32'd0);
    chk("multu_hi", 0, 32'hFFFF_FFFE);
    chk("multu_lo", 1, 32'h0000_0001);
    step();

    do_div("divu_dz", 4'b0100, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
    step();

    // mul leaves HI/LO alone
    set(4'b0010, 5'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mul_out", 3, 32'hFFFF_FFFA);
    chk("mul_stall", 2, 32'd0);
    step();
    set(4'd0, 5'd0, 32'd0, 32'd0);
    chk("mul_hi_keep", 0, 32'd5);
    chk("mul_lo_keep", 1, 32'hFFFF_FFFF);
    chk("rdata_idle", 4, 32'd0);
    step();

    // mthi then mfhi
    set(4'd0, 5'b00100, 32'h1234, 32'd0);
    step();
    set(4'd0, 5'b10000, 32'd0, 32'd0);
    chk("mfhi", 4, 32'h0000_1234);
    step();
    // mtlo with same-cycle mflo sees the old LO
    set(4'd0, 5'b01010, 32'hABCD, 32'd0);
    chk("mflo_nofwd", 4, 32'hFFFF_FFFF);
    step();
    set(4'd0, 5'b01000, 32'd0, 32'd0);
    chk("mflo_new", 4, 32'h0000_ABCD);
    step();

    // Operand/opcode changes mid-divide are ignored
    e.name = "divu_chg"; e.hi = 32'd0; e.lo = 32'd100; e.stalls = 33;
    div_q.push_back(e);
    set(4'b0100, 5'd0, 32'd1000, 32'd10);
    repeat (3) step();
    set(4'b0001, 5'b00110, 32'hDEAD, 32'd0);
    repeat (31) step();
    set(4'd0, 5'd0, 32'd0, 32'd0);
    chk("chg_hi_after", 0, 32'd0);
    chk("chg_lo_after", 1, 32'd100);
    step();

    // Reset during BUSY at counter 10 aborts without a partial write
    set(4'b1000, 5'd0, 32'd100, 32'd3);
    repeat (11) step();
    rst_n = 1'b0;
    set(4'd0, 5'd0, 32'd0, 32'd0);
    step();
    chk("abort_stall", 2, 32'd0);
    chk("abort_hi", 0, 32'd0);
    chk("abort_lo", 1, 32'd0);
    chk("abort_done", 5, 32'd0);
    step();
    rst_n = 1'b1;
    do_div("divu_9_3", 4'b0100, 32'd9, 32'd3, 32'd0, 32'd3, 33);
    step(); step();

    chk("pending_divs", 6, 32'd0);
    step();
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_hilo_unit.md
MD_HILO_UNIT -- requirements
Module: md_hilo_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port choice_md, input, 4 bits: one-hot {div, divu, mul, multu} from the control unit.
REQ-004 SHALL have port choice_hilo, input, 5 bits: {mfhi, mflo, mthi, mtlo, md_wr} from the control unit.
REQ-005 SHALL have port rs_data, input, 32 bits: operand A / dividend / mthi-mtlo source.
REQ-006 SHALL have port rt_data, input, 32 bits: operand B / divisor.
REQ-007 SHALL have port stall, output, 1 bit: freeze PC and register writes this cycle.
REQ-008 SHALL have port hilo_rdata, output, 32 bits: HI on mfhi, LO on mflo, else 0; combinational from registered HI/LO.
REQ-009 SHALL have port mul_out, output, 32 bits: low 32 bits of signed rs_data*rt_data; combinational.
REQ-010 SHALL have port div_done, output, 1 bit: high exactly in the DONE cycle.
REQ-011 SHALL have ports hi and lo, output, 32 bits each: current HI and LO register contents.

Function
REQ-012 SHALL hold 32-bit registers HI and LO, a 3-state FSM (IDLE, BUSY, DONE), a 5-bit iteration counter and latched operand/sign flags.
REQ-013 Issue priority for non-one-hot input SHALL be div > divu > multu > mthi/mtlo; mul never writes state.
REQ-014 In IDLE, mthi SHALL load HI <= rs_data and mtlo SHALL load LO <= rs_data at the next edge, with stall=0.
REQ-015 In IDLE, multu SHALL load {HI,LO} <= unsigned 64-bit rs_data*rt_data at the next edge, with stall=0.
REQ-016 mul SHALL drive mul_out only, leave HI/LO unchanged, and keep stall=0.
REQ-017 In IDLE with div/divu and rt_data!=0, the unit SHALL assert stall combinationally, latch |rs| and |rt| (raw values for divu) plus the quotient and remainder signs, clear the counter, and go to BUSY.
REQ-018 In BUSY, the unit SHALL perform one radix-2 restoring step per cycle for 32 cycles (counter 0..31), with stall=1.
REQ-019 At the edge ending counter=31, the unit SHALL write LO=quotient and HI=remainder and go to DONE.
REQ-020 Signed result rules: quotient truncates toward zero; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-021 Divide by zero (div or divu) SHALL bypass BUSY: stall=1 for the issue cycle, HI=rs_data, LO=0xFFFFFFFF, then DONE.
REQ-022 In DONE, stall SHALL be 0 and div_done=1; choice_md SHALL be ignored, because the same div instruction is still presented; the next state is IDLE.
REQ-023 Total stall for a nonzero divide SHALL be 33 cycles (issue + 32 BUSY); the instruction retires in cycle 34.
REQ-024 Operands SHALL be sampled only at issue; changes to rs_data, rt_data or choice_md during BUSY SHALL be ignored, and the operation SHALL run to completion.
REQ-025 mthi, mtlo and multu SHALL be ignored in BUSY and DONE.
REQ-026 hilo_rdata SHALL reflect register values only, with no forwarding of same-cycle writes.

Reset
REQ-027 With rst_n=0 at an edge, the unit SHALL set HI=0, LO=0, state=IDLE and counter=0, and drive stall=0 and div_done=0 from that edge on.
REQ-028 Reset SHALL abort any in-progress divide and SHALL NOT write any partial result.
REQ-029 The first issue SHALL be accepted in the first cycle after rst_n returns to 1.

Verification
REQ-030 divu rs=100, rt=7 -> stall high for 33 cycles, then div_done; HI=2, LO=14.
REQ-031 div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 stall cycles.
REQ-032 multu rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 next edge, stall never high.
REQ-033 divu rs=5, rt=0 -> stall for 1 cycle, HI=5, LO=0xFFFFFFFF, div_done next cycle.
REQ-034 div issued, rst_n=0 at BUSY counter=10 -> stall=0 and HI=LO=0 after that edge; a subsequent divu 9/3 gives LO=3, HI=0.
REQ-035 mul 0xFFFFFFFE*3 -> mul_out=0xFFFFFFFA with HI/LO unchanged; then mthi 0x1234 followed by mfhi -> hilo_rdata=0x00001234.
